biriscv_mulf_unit: RTL and testbench

- Out-of-pipe iterative Q16.16 fixed-point multiplier serving the MULF instruction class.
- Started by the issue stage when a MULF op enters E1; the pipeline controller stalls E1 until `writeback_valid_o` is high.
- The result is captured into the E2 result register when E1 advances.
- Output feeds the controller's `mulf_complete_i` and `mulf_result_i`.

---
 rtl/biriscv_mulf_unit_pkg.sv | 21 ++
 rtl/biriscv_mulf_unit_step.sv | 24 ++
 rtl/biriscv_mulf_unit.sv | 134 +++++++++++++
 tb/tb_biriscv_mulf_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_mulf_unit_pkg.sv
// Shared definitions for the MULF (Q16.16 fixed-point multiply) unit.
package biriscv_defs;

  localparam int          MULF_FUNC_ROUND_BIT    = 0;
  localparam int          MULF_FUNC_UNSIGNED_BIT = 1;
  localparam logic [31:0] MULF_ROUND_CONST       = 32'h8000;

  typedef enum logic [1:0] {
    MULF_IDLE = 2'd0,
    MULF_BUSY = 2'd1,
    MULF_FIX  = 2'd2,
    MULF_DONE = 2'd3
  } mulf_state_t;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [31:0] mulf_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/biriscv_mulf_unit_step.sv
// One iteration of the shift-add multiplier: retires BITS_PER_CYCLE
// multiplier bits against the (already shifted) multiplicand.
module biriscv_mulf_step
  import biriscv_defs::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [63:0]               i_acc,
  input  logic [63:0]               i_mcand,
  input  logic [BITS_PER_CYCLE-1:0] i_mplier_bits,
  output logic [63:0]               o_acc_next
);

  // Sum the selected partial products onto the running accumulator.
  always_comb begin
    o_acc_next = i_acc;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (i_mplier_bits[k]) begin
        o_acc_next = o_acc_next + (i_mcand << k);
      end
    end
  end

endmodule

// File: rtl/biriscv_mulf_unit.sv
// Iterative Q16.16 multiplier for the MULF instruction class.
// Operates on magnitudes, then rounds/shifts/saturates/negates in FIX.
module biriscv_mulf_unit
  import biriscv_defs::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [1:0]  opcode_func_i,
  input  logic [31:0] operand_ra_i,
  input  logic [31:0] operand_rb_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        busy_o,
  output logic        writeback_valid_o,
  output logic [31:0] writeback_value_o,
  output logic        writeback_sat_o
);

  localparam int         ITER      = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] ITER_LAST = 5'(ITER - 1);

  mulf_state_t r_state;
  mulf_state_t w_state_next;

  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_neg;
  logic        r_signed;
  logic        r_round;
  logic [31:0] r_value;
  logic        r_sat;

  logic        w_signed_in;
  logic        w_load;
  logic [63:0] w_acc_step;
  logic [63:0] w_p;
  logic [47:0] w_q;
  logic [47:0] w_limit;
  logic        w_over;
  logic [31:0] w_mag;
  logic [31:0] w_fix_value;

  assign w_signed_in = ~opcode_func_i[MULF_FUNC_UNSIGNED_BIT];
  assign w_load      = opcode_valid_i && !flush_i &&
                       ((r_state == MULF_IDLE) || (r_state == MULF_DONE));

  biriscv_mulf_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .i_acc         (r_acc),
    .i_mcand       (r_mcand),
    .i_mplier_bits (r_mplier[BITS_PER_CYCLE-1:0]),
    .o_acc_next    (w_acc_step)
  );

  // FIX stage: round half away from zero on the magnitude, drop 16 fraction
  // bits, clamp to the range of the result sign, then apply the sign.
  always_comb begin
    w_p     = r_acc + (r_round ? {32'd0, MULF_ROUND_CONST} : 64'd0);
    w_q     = 48'(w_p >> 16);
    w_limit = !r_signed ? 48'h0000_FFFF_FFFF :
              r_neg     ? 48'h0000_8000_0000 : 48'h0000_7FFF_FFFF;
    w_over  = (w_q > w_limit);
    w_mag   = w_over ? w_limit[31:0] : w_q[31:0];
    w_fix_value = r_neg ? (~w_mag + 32'd1) : w_mag;
  end

  // Next-state logic; flush squashes everything, including a same-cycle start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MULF_IDLE: if (opcode_valid_i) w_state_next = MULF_BUSY;
      MULF_BUSY: if (r_cnt == ITER_LAST) w_state_next = MULF_FIX;
      MULF_FIX:  w_state_next = MULF_DONE;
      MULF_DONE: begin
        if (opcode_valid_i)   w_state_next = MULF_BUSY;
        else if (!stall_i)    w_state_next = MULF_IDLE;
      end
      default:   w_state_next = MULF_IDLE;
    endcase
    if (flush_i) w_state_next = MULF_IDLE;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= MULF_IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath: operand capture, iteration, and result registration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
      r_round  <= 1'b0;
      r_value  <= '0;
      r_sat    <= 1'b0;
    end else if (!flush_i) begin
      if (w_load) begin
        r_acc    <= '0;
        r_mcand  <= {32'd0, mulf_abs(operand_ra_i, w_signed_in)};
        r_mplier <= mulf_abs(operand_rb_i, w_signed_in);
        r_cnt    <= '0;
        r_neg    <= w_signed_in & (operand_ra_i[31] ^ operand_rb_i[31]);
        r_signed <= w_signed_in;
        r_round  <= opcode_func_i[MULF_FUNC_ROUND_BIT];
      end else if (r_state == MULF_BUSY) begin
        r_acc    <= w_acc_step;
        r_mcand  <= r_mcand << BITS_PER_CYCLE;
        r_mplier <= r_mplier >> BITS_PER_CYCLE;
        r_cnt    <= r_cnt + 5'd1;
      end
      if (r_state == MULF_FIX) begin
        r_value <= w_fix_value;
        r_sat   <= w_over;
      end
    end
  end

  assign busy_o            = (r_state == MULF_BUSY) || (r_state == MULF_FIX);
  assign writeback_valid_o = (r_state == MULF_DONE);
  assign writeback_value_o = r_value;
  assign writeback_sat_o   = r_sat;

endmodule

// File: tb/tb_biriscv_mulf_unit.sv
// Bench for biriscv_mulf_unit: three instances (1/2/4 bits per cycle)
// share stimulus; a per-instance queue holds expected results.
module tb_biriscv_mulf_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, opv, flush, stall;
  logic [1:0]  func;
  logic [31:0] a, b;
  logic        busy[3], valid[3], sat[3];
  logic [31:0] val[3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int N = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      biriscv_mulf_unit #(.BITS_PER_CYCLE(N)) u_dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .opcode_valid_i    (opv),
        .opcode_func_i     (func),
        .operand_ra_i      (a),
        .operand_rb_i      (b),
        .flush_i           (flush),
        .stall_i           (stall),
        .busy_o            (busy[g]),
        .writeback_valid_o (valid[g]),
        .writeback_value_o (val[g]),
        .writeback_sat_o   (sat[g])
      );
    end
  endgenerate

  typedef struct {
    logic [31:0] v;
    logic        s;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  f;
    logic [31:0] v;
    logic        s;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_viol  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference written in signed 64-bit arithmetic, independent of the
  // magnitude datapath in the design.
  function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                input logic [1:0] f,
                                output logic [31:0] v, output logic s);
    logic [63:0] up;
    logic [63:0] uq;
    longint      p;
    longint      m;
    longint      q;
    if (f[1]) begin
      up = {32'd0, ia} * {32'd0, ib};
      if (f[0]) up = up + 64'h8000;
      uq = up >> 16;
      if (uq > 64'h0000_0000_FFFF_FFFF) begin
        v = 32'hFFFF_FFFF; s = 1'b1;
      end else begin
        v = uq[31:0]; s = 1'b0;
      end
    end else begin
      p = longint'($signed(ia)) * longint'($signed(ib));
      m = (p < 0) ? -p : p;
      if (f[0]) m = m + 64'sd32768;
      m = m >>> 16;
      q = (p < 0) ? -m : m;
      if (q > 64'sd2147483647) begin
        v = 32'h7FFF_FFFF; s = 1'b1;
      end else if (q < -64'sd2147483648) begin
        v = 32'h8000_0000; s = 1'b1;
      end else begin
        v = q[31:0]; s = 1'b0;
      end
    end
  endfunction

  function automatic exp_t pop_exp(input int k);
    exp_t e;
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    return e;
  endfunction

  // Issue one op to all instances and check each one's latency and result.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] f,
                       input logic [31:0] ev, input logic es, input string name);
    exp_t e;
    bit   seen[3];
    int   c;
    e.v = ev; e.s = es;
    e.lat = 33; q0.push_back(e);
    e.lat = 17; q1.push_back(e);
    e.lat = 9;  q2.push_back(e);
    a = ia; b = ib; func = f; opv = 1'b1;
    tick();
    opv = 1'b0;
    seen = '{1'b0, 1'b0, 1'b0};
    c = 0;
    while (c < 40 && !(seen[0] && seen[1] && seen[2])) begin
      c++;
      tick();
      for (int k = 0; k < 3; k++) begin
        if (valid[k] && !seen[k]) begin
          seen[k] = 1'b1;
          e = pop_exp(k);
          chk($sformatf("%s[%0d] latency", name, k), 32'(c), 32'(e.lat));
          chk($sformatf("%s[%0d] value", name, k), val[k], e.v);
          chk($sformatf("%s[%0d] sat", name, k), {31'd0, sat[k]}, {31'd0, e.s});
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!seen[k]) begin
        n_tests++; n_fail++;
        e = pop_exp(k);
        $display("FAIL %s[%0d] timeout: no valid, expected %h", name, k, e.v);
      end
    end
  endtask

  // Wait for the N=1 instance after the start edge has already passed.
  task automatic wait_u1(input int lat, input logic [31:0] ev, input logic es, input string name);
    int  c;
    bit  got;
    got = 1'b0;
    c   = 0;
    while (c < 40 && !got) begin
      c++;
      tick();
      if (valid[0]) begin
        got = 1'b1;
        chk({name, " latency"}, 32'(c), 32'(lat));
        chk({name, " value"}, val[0], ev);
        chk({name, " sat"}, {31'd0, sat[0]}, {31'd0, es});
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: no valid, expected %h", name, ev);
    end
  endtask

  // The controller never starts a MULF while the unit is busy.
  always @(posedge clk) begin
    if (!rst && !flush && opv && (busy[0] || busy[1] || busy[2])) begin
      n_viol++;
      $display("FAIL start_while_busy: got start with busy=%b%b%b required no start",
               busy[0], busy[1], busy[2]);
    end
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  vec_t vecs[9];
  int   nvalid;
  logic [31:0] rv, ra, rb;
  logic        rs;
  logic [1:0]  rf;

  initial begin
    vecs[0] = '{32'h0001_8000, 32'h0002_0000, 2'b00, 32'h0003_0000, 1'b0};
    vecs[1] = '{32'hFFFE_8000, 32'h0002_0000, 2'b00, 32'hFFFD_0000, 1'b0};
    vecs[2] = '{32'h0000_0001, 32'h0000_8000, 2'b00, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h0000_0001, 32'h0000_8000, 2'b01, 32'h0000_0001, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_8000, 2'b01, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{32'h7FFF_0000, 32'h0002_0000, 2'b00, 32'h7FFF_FFFF, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 2'b00, 32'h7FFF_FFFF, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h0001_0000, 2'b00, 32'h8000_0000, 1'b0};
    vecs[8] = '{32'hFFFF_0000, 32'h0002_0000, 2'b10, 32'hFFFF_FFFF, 1'b1};

    rst = 1'b1; opv = 1'b0; flush = 1'b0; stall = 1'b0;
    func = 2'b00; a = '0; b = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset busy", {31'd0, busy[0]}, 32'd0);
    chk("reset valid", {31'd0, valid[0]}, 32'd0);
    chk("reset value", val[0], 32'd0);
    chk("reset sat", {31'd0, sat[0]}, 32'd0);

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].v, vecs[i].s, $sformatf("vec%0d", i));

    // Hold in DONE under stall, then release.
    stall = 1'b1;
    a = 32'h0001_8000; b = 32'h0002_0000; func = 2'b00; opv = 1'b1;
    tick(); opv = 1'b0;
    wait_u1(33, 32'h0003_0000, 1'b0, "stall_first");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_hold%0d valid", i), {31'd0, valid[0]}, 32'd1);
      chk($sformatf("stall_hold%0d value", i), val[0], 32'h0003_0000);
    end
    stall = 1'b0;
    tick();
    chk("stall_release valid", {31'd0, valid[0]}, 32'd0);
    chk("stall_release busy", {31'd0, busy[0]}, 32'd0);

    // Back-to-back: new start in the release cycle.
    stall = 1'b1;
    a = 32'h0002_0000; b = 32'h0003_0000; opv = 1'b1;
    tick(); opv = 1'b0;
    wait_u1(33, 32'h0006_0000, 1'b0, "b2b_first");
    stall = 1'b0;
    a = 32'hFFFF_0000; b = 32'h0005_0000; opv = 1'b1;
    tick(); opv = 1'b0;
    chk("b2b valid_drop", {31'd0, valid[0]}, 32'd0);
    chk("b2b busy", {31'd0, busy[0]}, 32'd1);
    wait_u1(33, 32'hFFFB_0000, 1'b0, "b2b_second");

    // Flush at BUSY cycle 10.
    a = 32'h0001_8000; b = 32'h0002_0000; func = 2'b00; opv = 1'b1;
    tick(); opv = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_busy busy", {31'd0, busy[0]}, 32'd0);
    chk("flush_busy valid", {31'd0, valid[0]}, 32'd0);
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid[0] || valid[1] || valid[2]) nvalid++;
    end
    chk("flush_busy no_valid", 32'(nvalid), 32'd0);
    do_op(32'h0001_8000, 32'hFFFE_0000, 2'b00, 32'hFFFD_0000, 1'b0, "after_flush");

    // Flush in DONE together with a start: the start is dropped.
    stall = 1'b1;
    a = 32'h0001_0000; b = 32'h0001_0000; opv = 1'b1;
    tick(); opv = 1'b0;
    wait_u1(33, 32'h0001_0000, 1'b0, "flush_done_op");
    flush = 1'b1; opv = 1'b1; a = 32'h0004_0000; b = 32'h0004_0000;
    tick();
    flush = 1'b0; opv = 1'b0; stall = 1'b0;
    chk("flush_done valid", {31'd0, valid[0]}, 32'd0);
    chk("flush_done busy", {31'd0, busy[0]}, 32'd0);
    repeat (3) tick();
    chk("flush_start_ignored busy", {31'd0, busy[0]}, 32'd0);

    // Reset while BUSY clears all outputs.
    do_op(32'h7FFF_0000, 32'h0002_0000, 2'b00, 32'h7FFF_FFFF, 1'b1, "pre_reset");
    a = 32'h0003_0000; b = 32'h0002_0000; opv = 1'b1;
    tick(); opv = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst_busy busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_busy valid", {31'd0, valid[0]}, 32'd0);
    chk("rst_busy value", val[0], 32'd0);
    chk("rst_busy sat", {31'd0, sat[0]}, 32'd0);

    // Random sweep against the reference model.
    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) ra = {{14{ra[31]}}, ra[17:0]};
      if ($urandom_range(0, 2) == 0) rb = {{14{rb[31]}}, rb[17:0]};
      rf = 2'($urandom_range(0, 3));
      model(ra, rb, rf, rv, rs);
      do_op(ra, rb, rf, rv, rs, $sformatf("rand%0d", i));
    end

    n_fail = n_fail + n_viol;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
